// File: rtl/uart_tx_stream_if.sv
// rtl/uart_tx_stream_if.sv - word stream into the UART transmitter
interface uart_tx_stream_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] s_data;
  logic                  s_valid;
  logic                  s_ready;

  modport master (output s_data, output s_valid, input s_ready);
  modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/uart_tx_stream.sv
// rtl/uart_tx_stream.sv - UART transmitter with FIFO, run-time frame format and break
module uart_tx_stream #(
  parameter int DATA_WIDTH      = 8,
  parameter int FIFO_DEPTH_LOG2 = 4,
  parameter int DIV_WIDTH       = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  uart_tx_stream_if.slave          s,
  input  logic [3:0]               cfg_data_bits,
  input  logic                     cfg_parity_en,
  input  logic [1:0]               cfg_parity_mode,
  input  logic                     cfg_stop_bits,
  input  logic [DIV_WIDTH-1:0]     cfg_divisor,
  input  logic                     cfg_break,
  input  logic                     flush,
  output logic                     tx,
  output logic                     busy,
  output logic                     done,
  output logic [FIFO_DEPTH_LOG2:0] fifo_count,
  output logic                     fifo_empty,
  output logic                     fifo_full
);

  localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
  localparam logic [FIFO_DEPTH_LOG2:0] CNT_ONE = (FIFO_DEPTH_LOG2+1)'(1);
  localparam logic [FIFO_DEPTH_LOG2-1:0] PTR_ONE = FIFO_DEPTH_LOG2'(1);
  localparam logic [DIV_WIDTH-1:0] DIV_ONE = DIV_WIDTH'(1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK, BRK_STOP} state_t;

  logic [DATA_WIDTH-1:0]      mem [DEPTH];
  logic [FIFO_DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic                       push, pop;

  state_t                     state;
  logic [DIV_WIDTH-1:0]       baud_cnt, div_q;
  logic [3:0]                 bit_cnt, nbits_q, nbits_c;
  logic [DATA_WIDTH-1:0]      shift, head_masked;
  logic                       par_en_q, par_q, par_c, stop2_q, stop_cnt, brk_min;
  logic                       bit_end, stop_last, decide;

  // Count MSB is set only at exactly DEPTH words, so it doubles as the full flag.
  assign fifo_empty = (fifo_count == '0);
  assign fifo_full  = fifo_count[FIFO_DEPTH_LOG2];
  assign s.s_ready  = ~fifo_full & ~flush;
  assign push       = s.s_valid & s.s_ready;

  assign bit_end   = (baud_cnt == div_q);
  assign stop_last = bit_end & (stop_cnt == stop2_q);
  // A new frame or break may begin from IDLE or straight out of the last stop bit.
  assign decide    = (state == IDLE) | ((state == STOP) & stop_last) |
                     ((state == BRK_STOP) & bit_end & stop_cnt);
  assign pop       = decide & ~cfg_break & ~fifo_empty & ~flush;

  // Clamp the requested width and build the masked head word and its parity bit.
  always_comb begin
    nbits_c = cfg_data_bits;
    if (cfg_data_bits < 4'd5)
      nbits_c = 4'd5;
    else if (cfg_data_bits > 4'(DATA_WIDTH))
      nbits_c = 4'(DATA_WIDTH);
    head_masked = '0;
    for (int i = 0; i < DATA_WIDTH; i++)
      head_masked[i] = (i < int'(nbits_c)) ? mem[rd_ptr][i] : 1'b0;
    par_c = cfg_parity_mode[1] ? (^head_masked ^ cfg_parity_mode[0]) : cfg_parity_mode[0];
  end

  // FIFO storage write; pointers guard what is valid, so no reset is needed here.
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= s.s_data;
  end

  // FIFO pointers and occupancy; flush wins over a pop in the same cycle.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)
        rd_ptr <= rd_ptr + PTR_ONE;
      if (push && !pop)
        fifo_count <= fifo_count + CNT_ONE;
      else if (pop && !push)
        fifo_count <= fifo_count - CNT_ONE;
    end
  end

  // Frame FSM; line outputs are registered from the current state, one cycle behind it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      baud_cnt <= '0;
      div_q    <= '0;
      bit_cnt  <= '0;
      nbits_q  <= 4'd5;
      shift    <= '0;
      par_en_q <= 1'b0;
      par_q    <= 1'b0;
      stop2_q  <= 1'b0;
      stop_cnt <= 1'b0;
      brk_min  <= 1'b0;
      tx       <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      busy     <= (state != IDLE);
      done     <= (state == STOP) & stop_last;
      baud_cnt <= bit_end ? '0 : baud_cnt + DIV_ONE;
      case (state)
        START:   tx <= 1'b0;
        DATA:    tx <= shift[0];
        PARITY:  tx <= par_q;
        BREAK:   tx <= 1'b0;
        default: tx <= 1'b1;
      endcase

      case (state)
        IDLE: baud_cnt <= '0;
        START: begin
          bit_cnt <= '0;
          if (bit_end)
            state <= DATA;
        end
        DATA: begin
          if (bit_end) begin
            shift <= shift >> 1;
            if (bit_cnt == nbits_q - 4'd1) begin
              state    <= par_en_q ? PARITY : STOP;
              stop_cnt <= 1'b0;
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
            end
          end
        end
        PARITY: begin
          if (bit_end) begin
            state    <= STOP;
            stop_cnt <= 1'b0;
          end
        end
        STOP: begin
          if (bit_end && !stop_last)
            stop_cnt <= 1'b1;
        end
        BREAK: begin
          if (bit_end)
            brk_min <= 1'b1;
          if (!cfg_break && (brk_min || bit_end)) begin
            state    <= BRK_STOP;
            baud_cnt <= '0;
            stop_cnt <= 1'b0;
          end
        end
        BRK_STOP: begin
          if (bit_end && !stop_cnt)
            stop_cnt <= 1'b1;
        end
        default: state <= IDLE;
      endcase

      if (decide) begin
        baud_cnt <= '0;
        stop_cnt <= 1'b0;
        if (cfg_break) begin
          state   <= BREAK;
          div_q   <= cfg_divisor;
          brk_min <= 1'b0;
        end else if (pop) begin
          state    <= START;
          div_q    <= cfg_divisor;
          shift    <= head_masked;
          nbits_q  <= nbits_c;
          par_en_q <= cfg_parity_en;
          par_q    <= par_c;
          stop2_q  <= cfg_stop_bits;
        end else begin
          state <= IDLE;
        end
      end
    end
  end

endmodule

// File: doc/uart_tx_stream.md
# uart_tx_stream

Parametrised UART transmitter core with an integrated FIFO, a programmable integer baud divisor, run-time frame format (5 to DATA_WIDTH data bits, parity, 1/2 stop bits) and break generation. It accepts words on a valid/ready stream and replaces the fixed-format transmitter, clock generator and buffer trio. The core is bus-agnostic: AXI-lite wrappers drive its config and stream ports directly.

## Interface
- DATA_WIDTH, 8: maximum data bits per frame; legal range 5..9.
- FIFO_DEPTH_LOG2, 4: FIFO holds 2^FIFO_DEPTH_LOG2 words.
- DIV_WIDTH, 16: width of the baud divisor.
- clk  in  1  single clock for all logic.
- rst  in  1  synchronous, active-high reset.
- s_data  in  DATA_WIDTH  word to send, LSB first.
- s_valid  in  1  s_data valid.
- s_ready  out  1  equals ~fifo_full & ~flush; a push happens when s_valid & s_ready.
- cfg_data_bits  in  4  data bits per frame; values below 5 act as 5, values above DATA_WIDTH act as DATA_WIDTH.
- cfg_parity_en  in  1  adds a parity bit.
- cfg_parity_mode  in  2  11 odd, 10 even, 01 mark (1), 00 space (0).
- cfg_stop_bits  in  1  0: one stop bit, 1: two stop bits.
- cfg_divisor  in  DIV_WIDTH  bit period is cfg_divisor+1 clk cycles.
- cfg_break  in  1  requests a break condition.
- flush  in  1  clears the FIFO.
- tx  out  1  serial line; registered; idles high.
- busy  out  1  high while a frame or break sequence is active.
- done  out  1  one-cycle pulse at the end of each frame's last stop bit.
- fifo_count  out  FIFO_DEPTH_LOG2+1  number of words queued.
- fifo_empty, fifo_full  out  1 each  FIFO flags.

## Operation
- FSM states: IDLE, START, DATA, PARITY, STOP, BREAK, BRK_STOP.
- IDLE -> BREAK when cfg_break=1. This takes priority over a non-empty FIFO.
- IDLE -> START when the FIFO is not empty. On that transition the head word is popped into the shift register and all cfg_* values except cfg_break are latched for the frame.
- Config changes during a frame do not affect the current frame.
- START: tx=0 for one bit period, then DATA.
- DATA: shifts out the latched number of bits, LSB first. A bit counter counts from 0 to data_bits-1. Bits of s_data above data_bits are ignored.
- DATA -> PARITY if parity is enabled, otherwise DATA -> STOP.
- Parity value:
  - even: XOR of the used bits.
  - odd: inverse of that XOR.
  - mark: 1.
  - space: 0.
- STOP: tx=1 for 1 or 2 bit periods. At the end, done pulses and the FSM returns to IDLE. The IDLE decision is taken in that same cycle, so back-to-back frames have no gap.
- cfg_break asserted mid-frame: the frame completes first. The break starts at the next IDLE decision.
- BREAK: tx=0 while cfg_break=1. Minimum duration is one bit period, using the divisor sampled on entry.
- BREAK -> BRK_STOP when cfg_break=0. BRK_STOP holds tx=1 for 2 bit periods, then IDLE.
- Baud counter: counts 0..divisor and resets on every state change. A bit ends when the counter equals the divisor; cfg_divisor=0 gives 1 clk per bit.
- FIFO: circular buffer with read and write pointers of FIFO_DEPTH_LOG2 bits; both wrap modulo depth.
  - push & pop in the same cycle: fifo_count unchanged.
  - push is impossible when full, because s_ready=0.
  - pop only occurs from a non-empty FIFO.
- flush: pointers and count are cleared on the next edge. A frame already in progress completes unchanged.
- Reset values:
  - tx=1, busy=0, done=0.
  - fifo_count=0, fifo_empty=1, fifo_full=0.
  - s_ready=1 (with flush=0).
  - FSM in IDLE, counters at 0.
  - Reset mid-frame aborts the frame; tx is high on the next cycle.

## Timing
- Push accepted at edge N into an empty FIFO with the FSM in IDLE:
  - fifo_empty falls after edge N.
  - The pop occurs at edge N+1.
  - tx is low from edge N+2.
  - fifo_count returns to 0 after edge N+1.
- Frame length is exactly (1 + data_bits + parity_en + stop_bits) × (divisor+1) cycles.
- done is high during the final cycle of the last stop bit.
- busy rises with the start bit and stays high through contiguous frames. It falls the cycle after the last stop bit ends when the FIFO is empty.
- busy is also high through BREAK and BRK_STOP.
- s_ready and the FIFO flags are registered-state based, with no combinational path from s_valid.

## Test plan
- Reset: assert rst 3 cycles -> tx=1, busy=0, s_ready=1, fifo_count=0, fifo_empty=1.
- 8N1, divisor=3, push 0xA5 -> tx low 4 clks, then bits 1,0,1,0,0,1,0,1 at 4 clks each, high 4 clks. done pulses 40 clks after the start bit begins.
- 7E2, divisor=0, push 0x41 -> 11-clk frame: 0, 1000001, parity 0, 1, 1. With odd parity -> parity bit 1.
- DATA_WIDTH=9, 9O1, push 0x1FF -> 9 ones followed by parity 0. Push 16 words while tx stalls -> 17th push refused (s_ready=0). Frames are contiguous with no idle gap, and fifo_count steps 16..0.
- Break: assert cfg_break during DATA with 2 words queued -> frame completes, tx=0 until release, then 2 bit periods high, then the queued frames.
- Flush with 5 words queued mid-frame -> current frame finishes, fifo_count=0 next cycle, no further start bit. Then rst mid-frame -> tx=1 the following cycle.
